// File: rtl/uart_pkg.sv
// Shared types and constants for the two-requester UART transmit arbiter.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Index (0 or 1) of the requester named by a one-hot grant.
    function automatic logic owner_of(input logic [1:0] onehot);
        return onehot[1];
    endfunction

endpackage

// File: rtl/uart_arb_pick.sv
// Combinational winner selection between two requesters.
// Build option: define UART_ARB_PRIO_EN for fixed priority (requester 0 wins ties);
// otherwise ties go to the requester that was not served last.
module uart_arb_pick (
    input  logic       req0,
    input  logic       req1,
    input  logic       last_served,
    output logic [1:0] pick
);

`ifdef UART_ARB_PRIO_EN
    // Fixed priority ignores history.
    logic unused_last_served;
    assign unused_last_served = last_served;
`endif

    // One-hot winner; 2'b00 when nobody requests.
    always_comb begin
        // NOTE: default every output first so no path leaves it unassigned (no latch).
        pick = 2'b00;
        if (req0 && req1) begin
`ifdef UART_ARB_PRIO_EN
            pick = 2'b01;
`else
            pick = last_served ? 2'b01 : 2'b10;
`endif
        end else if (req0) begin
            pick = 2'b01;
        end else if (req1) begin
            pick = 2'b10;
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Two-requester arbiter feeding a UART transmit FIFO write port.
// Grants are packet-locked and capped at MAX_BURST bytes (legal 1..255).
// Build option: UART_ARB_PRIO_EN selects fixed priority instead of round-robin.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [BYTE_W-1:0] data0,
    input  logic [BYTE_W-1:0] data1,
    input  logic              last0,
    input  logic              last1,
    output logic              ack0,
    output logic              ack1,
    input  logic              tx_full,
    output logic [BYTE_W-1:0] w_data,
    output logic              wr,
    output logic [1:0]        grant,
    output logic              busy
);

    localparam logic [BYTE_W-1:0] BURST_END = BYTE_W'(MAX_BURST - 1);

    state_t            state;
    logic [BYTE_W-1:0] count;
    logic              last_served;
    logic [1:0]        pick;

    logic              owner_req;
    logic              owner_last;
    logic [BYTE_W-1:0] owner_data;
    logic              xfer;

    uart_arb_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_served (last_served),
        .pick        (pick)
    );

    // Mux the current owner's handshake and decide whether a byte moves this cycle.
    // Reset gates the transfer so an aborted packet emits no write in the reset cycle.
    always_comb begin
        owner_req  = 1'b0;
        owner_last = 1'b0;
        owner_data = '0;
        if (grant[0]) begin
            owner_req  = req0;
            owner_last = last0;
            owner_data = data0;
        end else if (grant[1]) begin
            owner_req  = req1;
            owner_last = last1;
            owner_data = data1;
        end
        xfer   = (state == XFER) && owner_req && !tx_full && !reset;
        wr     = xfer;
        ack0   = xfer && grant[0];
        ack1   = xfer && grant[1];
        w_data = xfer ? owner_data : '0;
    end

    // Two-state grant FSM with registered grant/busy, byte counter and round-robin history.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state       <= IDLE;
            grant       <= 2'b00;
            busy        <= 1'b0;
            count       <= '0;
            last_served <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (pick != 2'b00) begin
                        state <= XFER;
                        grant <= pick;
                        busy  <= 1'b1;
                        count <= '0;
                    end
                end
                XFER: begin
                    if (xfer) begin
                        if (owner_last || count == BURST_END) begin
                            state       <= IDLE;
                            grant       <= 2'b00;
                            busy        <= 1'b0;
                            last_served <= owner_of(grant);
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb built with MAX_BURST=4.
// Expected writes are queued as stimulus is loaded and compared as wr fires.
module tb_uart_tx_arb;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } beat_t;

    typedef struct packed {
        logic [1:0] grant;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       last0 = 1'b0, last1 = 1'b0;
    logic       ack0, ack1;
    logic       tx_full = 1'b0;
    logic [7:0] w_data;
    logic       wr;
    logic [1:0] grant;
    logic       busy;

    int errors = 0;
    int checks = 0;

    beat_t q0[$];
    beat_t q1[$];
    exp_t  exp_q[$];

    uart_tx_arb #(.MAX_BURST(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .data0   (data0),
        .data1   (data1),
        .last0   (last0),
        .last1   (last1),
        .ack0    (ack0),
        .ack1    (ack1),
        .tx_full (tx_full),
        .w_data  (w_data),
        .wr      (wr),
        .grant   (grant),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every write must match the next expected byte and owner.
    always @(negedge clk) begin
        exp_t e;
        if (wr === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_wr: got w_data=%h grant=%b, required no write", w_data, grant);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (w_data !== e.data) begin
                    errors++;
                    $display("FAIL sb_data: got %h required %h", w_data, e.data);
                end
                checks++;
                if (grant !== e.grant) begin
                    errors++;
                    $display("FAIL sb_grant: got %b required %b", grant, e.grant);
                end
                checks++;
                if ({ack1, ack0} !== e.grant) begin
                    errors++;
                    $display("FAIL sb_ack: got %b required %b", {ack1, ack0}, e.grant);
                end
            end
        end else begin
            checks++;
            if (w_data !== 8'h00 || {ack1, ack0} !== 2'b00) begin
                errors++;
                $display("FAIL idle_outputs: got w_data=%h acks=%b required 00/00", w_data, {ack1, ack0});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic drive();
        req0  = (q0.size() != 0);
        data0 = req0 ? q0[0].data : 8'h00;
        last0 = req0 ? q0[0].last : 1'b0;
        req1  = (q1.size() != 0);
        data1 = req1 ? q1[0].data : 8'h00;
        last1 = req1 ? q1[0].last : 1'b0;
    endtask

    // Called at the negedge after checks: consume acked beats and re-drive after the edge.
    task automatic adv();
        logic a0, a1;
        a0 = ack0;
        a1 = ack1;
        @(posedge clk);
        #1;
        if (a0 && q0.size() != 0) q0.delete(0);
        if (a1 && q1.size() != 0) q1.delete(0);
        drive();
    endtask

    task automatic expect_wr(input logic [1:0] g, input logic [7:0] d);
        exp_q.push_back({g, d});
    endtask

    task automatic drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending writes required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tx_full = 1'b0;
        q0.delete();
        q1.delete();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b required 00", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL rst_wr: got %b required 0", wr); end
        checks++; if (w_data !== 8'h00) begin errors++; $display("FAIL rst_wdata: got %h required 00", w_data); end
        checks++; if ({ack1, ack0} !== 2'b00) begin errors++; $display("FAIL rst_ack: got %b required 00", {ack1, ack0}); end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_contention();
        logic exp_wr;
        q0.push_back({1'b1, 8'h10});
        q0.push_back({1'b1, 8'h11});
        q1.push_back({1'b1, 8'h20});
        q1.push_back({1'b1, 8'h21});
`ifdef UART_ARB_PRIO_EN
        expect_wr(2'b01, 8'h10);
        expect_wr(2'b01, 8'h11);
        expect_wr(2'b10, 8'h20);
        expect_wr(2'b10, 8'h21);
`else
        expect_wr(2'b01, 8'h10);
        expect_wr(2'b10, 8'h20);
        expect_wr(2'b01, 8'h11);
        expect_wr(2'b10, 8'h21);
`endif
        drive();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp_wr = ((i % 2) == 1);
            checks++;
            if (wr !== exp_wr) begin errors++; $display("FAIL cont_wr_c%0d: got %b required %b", i, wr, exp_wr); end
            adv();
        end
        drained("cont");
    endtask

    task automatic test_single_packet();
        q0.push_back({1'b0, 8'hA5});
        q0.push_back({1'b1, 8'h3C});
        expect_wr(2'b01, 8'hA5);
        expect_wr(2'b01, 8'h3C);
        drive();
        @(negedge clk);
        checks++; if (wr !== 1'b0 || ack0 !== 1'b0) begin errors++; $display("FAIL single_idle: got wr=%b ack0=%b required 0/0", wr, ack0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b required 0", busy); end
        adv();
        @(negedge clk);
        checks++; if (busy !== 1'b1 || grant !== 2'b01) begin errors++; $display("FAIL single_grant: got busy=%b grant=%b required 1/01", busy, grant); end
        checks++; if (wr !== 1'b1 || w_data !== 8'hA5) begin errors++; $display("FAIL single_b0: got wr=%b data=%h required 1/a5", wr, w_data); end
        adv();
        @(negedge clk);
        checks++; if (wr !== 1'b1 || w_data !== 8'h3C) begin errors++; $display("FAIL single_b1: got wr=%b data=%h required 1/3c", wr, w_data); end
        adv();
        @(negedge clk);
        checks++; if (grant !== 2'b00 || busy !== 1'b0 || wr !== 1'b0) begin errors++; $display("FAIL single_end: got grant=%b busy=%b wr=%b required 00/0/0", grant, busy, wr); end
        adv();
        drained("single");
    endtask

    task automatic test_backpressure();
        q1.push_back({1'b0, 8'hD1});
        q1.push_back({1'b0, 8'hD2});
        q1.push_back({1'b1, 8'hD3});
        expect_wr(2'b10, 8'hD1);
        expect_wr(2'b10, 8'hD2);
        expect_wr(2'b10, 8'hD3);
        drive();
        @(negedge clk);
        adv();
        @(negedge clk);
        checks++; if (wr !== 1'b1 || w_data !== 8'hD1) begin errors++; $display("FAIL bp_first: got wr=%b data=%h required 1/d1", wr, w_data); end
        adv();
        tx_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (wr !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b1 || grant !== 2'b10) begin
                errors++;
                $display("FAIL bp_stall_c%0d: got wr=%b ack1=%b busy=%b grant=%b required 0/0/1/10", k, wr, ack1, busy, grant);
            end
            adv();
        end
        tx_full = 1'b0;
        @(negedge clk);
        checks++; if (wr !== 1'b1 || w_data !== 8'hD2) begin errors++; $display("FAIL bp_resume: got wr=%b data=%h required 1/d2", wr, w_data); end
        adv();
        @(negedge clk);
        checks++; if (w_data !== 8'hD3) begin errors++; $display("FAIL bp_last: got %h required d3", w_data); end
        adv();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_end_busy: got %b required 0", busy); end
        adv();
        drained("bp");
    endtask

    task automatic test_burst_limit();
        for (int d = 0; d < 6; d++) q1.push_back({1'b0, 8'(8'h60 + d)});
        for (int d = 0; d < 4; d++) expect_wr(2'b10, 8'(8'h60 + d));
        drive();
        @(negedge clk);
        adv();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (wr !== 1'b1 || grant !== 2'b10 || w_data !== 8'(8'h60 + i)) begin
                errors++;
                $display("FAIL burst_b%0d: got wr=%b grant=%b data=%h required 1/10/%h", i, wr, grant, w_data, 8'(8'h60 + i));
            end
            adv();
        end
        q0.push_back({1'b1, 8'h7A});
        expect_wr(2'b01, 8'h7A);
        expect_wr(2'b10, 8'h64);
        expect_wr(2'b10, 8'h65);
        drive();
        @(negedge clk);
        checks++; if (wr !== 1'b0 || grant !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL burst_gap: got wr=%b grant=%b busy=%b required 0/00/0", wr, grant, busy); end
        adv();
        @(negedge clk);
        checks++; if (grant !== 2'b01 || w_data !== 8'h7A) begin errors++; $display("FAIL burst_rr: got grant=%b data=%h required 01/7a", grant, w_data); end
        adv();
        @(negedge clk);
        adv();
        repeat (2) begin
            @(negedge clk);
            adv();
        end
        @(negedge clk);
        checks++; if (wr !== 1'b0 || grant !== 2'b10 || busy !== 1'b1) begin errors++; $display("FAIL lock_hold: got wr=%b grant=%b busy=%b required 0/10/1", wr, grant, busy); end
        adv();
        q0.push_back({1'b1, 8'h7B});
        drive();
        @(negedge clk);
        checks++; if (ack0 !== 1'b0 || wr !== 1'b0 || grant !== 2'b10) begin errors++; $display("FAIL lock_nonowner: got ack0=%b wr=%b grant=%b required 0/0/10", ack0, wr, grant); end
        adv();
        q1.push_back({1'b1, 8'h66});
        expect_wr(2'b10, 8'h66);
        expect_wr(2'b01, 8'h7B);
        drive();
        @(negedge clk);
        checks++; if (wr !== 1'b1 || w_data !== 8'h66) begin errors++; $display("FAIL lock_release: got wr=%b data=%h required 1/66", wr, w_data); end
        adv();
        @(negedge clk);
        adv();
        @(negedge clk);
        checks++; if (grant !== 2'b01 || w_data !== 8'h7B) begin errors++; $display("FAIL lock_next: got grant=%b data=%h required 01/7b", grant, w_data); end
        adv();
        @(negedge clk);
        adv();
        drained("burst");
    endtask

    task automatic test_reset_mid_xfer();
        for (int d = 0; d < 4; d++) q0.push_back({1'b0, 8'(8'h80 + d)});
        q0.push_back({1'b1, 8'h84});
        expect_wr(2'b01, 8'h80);
        expect_wr(2'b01, 8'h81);
        drive();
        repeat (3) begin
            @(negedge clk);
            adv();
        end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (wr !== 1'b0 || ack0 !== 1'b0 || w_data !== 8'h00) begin errors++; $display("FAIL rstx_abort: got wr=%b ack0=%b data=%h required 0/0/00", wr, ack0, w_data); end
        adv();
        reset = 1'b0;
        q0.delete();
        q1.delete();
        q0.push_back({1'b1, 8'h90});
        q1.push_back({1'b1, 8'hA0});
        expect_wr(2'b01, 8'h90);
        expect_wr(2'b10, 8'hA0);
        drive();
        @(negedge clk);
        checks++; if (grant !== 2'b00 || busy !== 1'b0 || wr !== 1'b0 || {ack1, ack0} !== 2'b00) begin errors++; $display("FAIL rstx_state: got grant=%b busy=%b wr=%b acks=%b required 00/0/0/00", grant, busy, wr, {ack1, ack0}); end
        adv();
        @(negedge clk);
        checks++; if (grant !== 2'b01 || w_data !== 8'h90) begin errors++; $display("FAIL rstx_tie: got grant=%b data=%h required 01/90", grant, w_data); end
        adv();
        repeat (3) begin
            @(negedge clk);
            adv();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstx_end_busy: got %b required 0", busy); end
        drained("rstx");
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_packet();
        test_backpressure();
        test_burst_limit();
        test_reset_mid_xfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
